// File: rtl/round_robin_arbiter_pkg.sv
// rtl/round_robin_arbiter_pkg.sv - shared requester count, state encodings and grant decode helper
package round_robin_arbiter_pkg;

  localparam int RR_N  = 4;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S0_IDLE    = 2'd0,
    S1_GRANT   = 2'd1,
    S2_HOLD    = 2'd2,
    S3_RELEASE = 2'd3
  } rr_state_t;

  function automatic logic [RR_N-1:0] rr_onehot(input logic [1:0] idx);
    logic [RR_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/round_robin_arbiter_rr_pick.sv
// rtl/round_robin_arbiter_rr_pick.sv - rotating-priority search: first set req starting at ptr
module rr_pick
  import round_robin_arbiter_pkg::*;
(
  input  logic [RR_N-1:0] req,
  input  logic [1:0]      ptr,
  output logic [1:0]      idx,
  output logic            any
);

  logic [1:0] cand;

  // Walk from the farthest offset back to ptr so the nearest hit is written last.
  always_comb begin
    idx  = ptr;
    any  = 1'b0;
    cand = ptr;
    for (int k = RR_N - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// rtl/round_robin_arbiter.sv - 4-way round-robin arbiter with hold timeout and JK busy-flag pulses
module round_robin_arbiter
  import round_robin_arbiter_pkg::*;
#(
  parameter int N       = RR_N,
  parameter int TIMEOUT = 8
) (
  input  logic         Ck,
  input  logic         reset_,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] gnt,
  output logic         J,
  output logic         K,
  output logic         tout
);

  rr_state_t        state;
  rr_state_t        next_state;
  logic [1:0]       ptr;
  logic [1:0]       owner;
  logic [CNT_W-1:0] cnt;
  logic             cause;
  logic [1:0]       pick_idx;
  logic             pick_any;
  logic             cnt_last;
  logic             hold_exit;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign cnt_last  = (cnt == CNT_W'(TIMEOUT - 1));
  assign hold_exit = done | ~req[owner] | cnt_last;

  always_ff @(posedge Ck or negedge reset_) begin
    if (!reset_) begin
      state <= S0_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Outputs decode only the registered state, so a mid-grant reset drops gnt with no K pulse.
  always_comb begin
    next_state = state;
    gnt        = '0;
    J          = 1'b0;
    K          = 1'b0;
    tout       = 1'b0;
    case (state)
      S0_IDLE: begin
        if (pick_any) next_state = S1_GRANT;
      end
      S1_GRANT: begin
        gnt        = rr_onehot(owner);
        J          = 1'b1;
        next_state = S2_HOLD;
      end
      S2_HOLD: begin
        gnt = rr_onehot(owner);
        if (hold_exit) next_state = S3_RELEASE;
      end
      S3_RELEASE: begin
        K          = 1'b1;
        tout       = cause;
        next_state = S0_IDLE;
      end
    endcase
  end

  always_ff @(posedge Ck or negedge reset_) begin
    if (!reset_) begin
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
      cause <= 1'b0;
    end else begin
      case (state)
        S0_IDLE: begin
          if (pick_any) owner <= pick_idx;
        end
        S1_GRANT: begin
          cnt   <= '0;
          cause <= 1'b0;
        end
        S2_HOLD: begin
          // A done arriving on the timeout cycle is a normal release, not a timeout.
          if (hold_exit) cause <= cnt_last & ~done & req[owner];
          else           cnt   <= cnt + 1'b1;
        end
        S3_RELEASE: begin
          ptr <= owner + 2'd1;
        end
      endcase
    end
  end

endmodule
